lsu_ctrl: RTL and testbench

- Load/store controller directly upstream of the 128 x 32-bit data SRAM; owns that SRAM's write port and one of its read ports.
- Accepts byte-addressed load/store requests from the core's memory stage over a valid/ready handshake.
- Performs sub-word stores as read-modify-write and sign/zero-extends sub-word loads.
- Returns one response per request, with an error flag for misaligned or illegal accesses.

---
 rtl/lsu_ctrl.sv | 173 +++++++++++++++++
 tb/tb_lsu_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store controller in front of the 128 x 32-bit data SRAM.
//
// Takes one byte-addressed load or store at a time from the memory stage and
// returns one response for it. Sub-word stores are read-modify-write: the
// word is read, the selected lanes are merged in, and the word is written
// back. Sub-word loads are sign- or zero-extended. A misaligned access or
// size 2'b11 is answered with resp_err=1 and no SRAM access.
//
// Handshakes: a transfer happens on a posedge where valid && ready are both
// high. A request is taken only in IDLE (req_ready = state is IDLE). A
// response is offered in RESP (resp_valid = state is RESP), and its data and
// flag stay stable until it is taken.
//
// Ports:
//   clk, reset      clock; synchronous active-low reset
//   req_*           request channel (valid/ready, we, size, unsigned, addr, wdata)
//   resp_*          response channel (valid/ready, rdata, err)
//   mem_raddr/rdata SRAM read port 1 (combinational read data)
//   mem_waddr/wdata/we  SRAM write port
//   dbg_state       current FSM state (0 IDLE, 1 READ, 2 WRITE, 3 RESP)

module lsu_ctrl #(
  parameter int BYTE_ADDR_W = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [1:0]             req_size,
  input  logic                   req_unsigned,
  input  logic [BYTE_ADDR_W-1:0] req_addr,
  input  logic [31:0]            req_wdata,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [31:0]            resp_rdata,
  output logic                   resp_err,
  output logic [BYTE_ADDR_W-3:0] mem_raddr,
  input  logic [31:0]            mem_rdata,
  output logic [BYTE_ADDR_W-3:0] mem_waddr,
  output logic [31:0]            mem_wdata,
  output logic                   mem_we,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                 state;
  logic [BYTE_ADDR_W-1:0] addr_q;
  logic [1:0]             size_q;
  logic                   we_q;
  logic                   unsigned_q;
  logic [31:0]            wdata_q;
  logic [31:0]            rdata_q;

  // Half with addr[0] set, word not on a 4-byte boundary, or size 2'b11.
  function automatic logic is_bad(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   is_bad = 1'b0;
      2'b01:   is_bad = lo[0];
      2'b10:   is_bad = (lo != 2'b00);
      default: is_bad = 1'b1;
    endcase
  endfunction

  // Shift the selected lane(s) down to bit 0, then extend from the lane MSB.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lo,
                                              input logic        uns);
    logic [31:0] sh;
    sh = word >> {lo, 3'b000};
    case (size)
      2'b00:   load_extend = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   load_extend = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: load_extend = word;
    endcase
  endfunction

  // Replace the selected lane(s) of old with the low bits of data; the
  // other lanes pass through unchanged.
  function automatic logic [31:0] store_merge(input logic [31:0] old,
                                              input logic [31:0] data,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lo);
    logic [31:0] mask;
    logic [31:0] ins;
    case (size)
      2'b00: begin
        mask = 32'h0000_00ff << {lo, 3'b000};
        ins  = {24'h0, data[7:0]} << {lo, 3'b000};
      end
      2'b01: begin
        mask = 32'h0000_ffff << {lo[1], 4'b0000};
        ins  = {16'h0, data[15:0]} << {lo[1], 4'b0000};
      end
      default: begin
        mask = 32'hffff_ffff;
        ins  = data;
      end
    endcase
    store_merge = (old & ~mask) | (ins & mask);
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      size_q     <= 2'b00;
      we_q       <= 1'b0;
      unsigned_q <= 1'b0;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q     <= req_addr;
            size_q     <= req_size;
            we_q       <= req_we;
            unsigned_q <= req_unsigned;
            wdata_q    <= req_wdata;
            if (is_bad(req_size, req_addr[1:0])) begin
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
              state      <= RESP;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          rdata_q <= mem_rdata;
          if (we_q) begin
            state <= WRITE;
          end else begin
            resp_rdata <= load_extend(mem_rdata, size_q, addr_q[1:0], unsigned_q);
            state      <= RESP;
          end
        end
        WRITE: begin
          // The SRAM commits mem_wdata at this posedge.
          resp_rdata <= 32'h0;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign mem_we     = (state == WRITE);
  assign mem_raddr  = addr_q[BYTE_ADDR_W-1:2];
  assign mem_waddr  = addr_q[BYTE_ADDR_W-1:2];
  assign mem_wdata  = store_merge(rdata_q, wdata_q, size_q, addr_q[1:0]);
  assign dbg_state  = state;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Testbench for lsu_ctrl: a behavioural SRAM on the memory ports, and a
// byte-array reference model of memory that predicts every response.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [6:0]  mem_raddr, mem_waddr;
  logic [31:0] mem_rdata, mem_wdata;
  logic        mem_we;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  lsu_ctrl #(.BYTE_ADDR_W(9)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .dbg_state(dbg_state)
  );

  // SRAM: combinational read, write on posedge.
  logic [31:0] sram [128];
  assign mem_rdata = sram[mem_raddr];
  always @(posedge clk) if (mem_we) sram[mem_waddr] <= mem_wdata;

  // Write-port monitor.
  int          we_cnt;
  logic [6:0]  we_addr;
  logic [31:0] we_data;
  always @(negedge clk) begin
    if (mem_we) begin
      we_cnt  = we_cnt + 1;
      we_addr = mem_waddr;
      we_data = mem_wdata;
    end
  end

  // ---------------- reference model ----------------
  logic [7:0]  ref_bytes [512];
  logic [31:0] exp_q [$];
  logic [31:0] last_rdata;

  function automatic int size_bytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_word(input int waddr);
    return {ref_bytes[waddr*4+3], ref_bytes[waddr*4+2],
            ref_bytes[waddr*4+1], ref_bytes[waddr*4]};
  endfunction

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [8:0] addr, input logic [31:0] wdata,
                        input int hold);
    int          n, lat, exp_lat;
    logic        exp_err;
    logic [31:0] v, exp_w, held;
    n = size_bytes(size);
    exp_err = (size == 2'b11) || ((int'(addr) % n) != 0);
    v = 32'h0;
    exp_w = 32'h0;
    if (!exp_err && !we) begin
      for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[int'(addr) + i]) << (8 * i));
      if (!uns && n < 4 && v[8*n-1]) v = v | (32'hffff_ffff << (8 * n));
    end
    if (!exp_err && we) begin
      for (int i = 0; i < n; i++) ref_bytes[int'(addr) + i] = wdata[8*i +: 8];
      exp_w = ref_word(int'(addr) / 4);
    end
    exp_q.push_back(v);
    exp_lat = exp_err ? 1 : (we ? 3 : 2);

    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    we_cnt = 0;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    last_rdata = resp_rdata;
    chk("rdata", resp_rdata, exp_q.pop_front());
    chk("err", 32'(resp_err), 32'(exp_err));

    // Back-pressure: response must hold, new requests must be refused.
    held = resp_rdata;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 9'h0;
      req_wdata = $urandom;
      @(negedge clk);
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_rdata", resp_rdata, held);
      chk("hold_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_clear", {resp_valid, resp_err, resp_rdata != 32'h0}, 32'd0);
    chk("back_idle", 32'(req_ready), 32'd1);

    chk("we_count", 32'(we_cnt), (we && !exp_err) ? 32'd1 : 32'd0);
    if (we && !exp_err) begin
      chk("waddr", 32'(we_addr), 32'(addr >> 2));
      chk("wdata", we_data, exp_w);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic        we, uns;
    logic [1:0]  size;
    logic [8:0]  addr;

    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 9'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    we_cnt = 0; we_addr = 7'h0; we_data = 32'h0; last_rdata = 32'h0;
    for (int w = 0; w < 128; w++) begin
      logic [31:0] r;
      r = $urandom;
      sram[w] = r;
      for (int b = 0; b < 4; b++) ref_bytes[w*4+b] = r[8*b +: 8];
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Word store then load.
    do_req(1'b1, 2'b10, 1'b0, 9'h010, 32'hDEADBEEF, 0);
    chk("p1_wdata", we_data, 32'hDEADBEEF);
    do_req(1'b0, 2'b10, 1'b0, 9'h010, 32'h0, 0);
    chk("p1_load", last_rdata, 32'hDEADBEEF);

    // Byte RMW.
    do_req(1'b1, 2'b10, 1'b0, 9'h020, 32'h11223344, 0);
    do_req(1'b1, 2'b00, 1'b0, 9'h022, 32'h000000AA, 1);
    chk("p2_wdata", we_data, 32'h11AA3344);
    do_req(1'b0, 2'b10, 1'b0, 9'h020, 32'h0, 0);
    chk("p2_load", last_rdata, 32'h11AA3344);

    // Extension.
    do_req(1'b1, 2'b10, 1'b0, 9'h030, 32'h80F17F01, 0);
    do_req(1'b0, 2'b01, 1'b0, 9'h032, 32'h0, 0);
    chk("p3_hs", last_rdata, 32'hFFFF80F1);
    do_req(1'b0, 2'b01, 1'b1, 9'h032, 32'h0, 0);
    chk("p3_hu", last_rdata, 32'h000080F1);
    do_req(1'b0, 2'b00, 1'b0, 9'h031, 32'h0, 0);
    chk("p3_b1", last_rdata, 32'h0000007F);
    do_req(1'b0, 2'b00, 1'b0, 9'h033, 32'h0, 0);
    chk("p3_b3", last_rdata, 32'hFFFFFF80);

    // Errors.
    do_req(1'b0, 2'b10, 1'b0, 9'h005, 32'h0, 0);
    do_req(1'b1, 2'b01, 1'b0, 9'h003, 32'h1234, 0);
    do_req(1'b0, 2'b11, 1'b0, 9'h000, 32'h0, 0);

    // Long back-pressure.
    do_req(1'b0, 2'b10, 1'b0, 9'h030, 32'h0, 5);

    // Reset during READ of a store: no write may occur.
    we_cnt = 0;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 9'h040; req_wdata = 32'h12345678;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_in_read", 32'(dbg_state), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_valid", 32'(resp_valid), 32'd0);
    chk("abort_mem_we", 32'(mem_we), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("abort_no_write", 32'(we_cnt), 32'd0);
    do_req(1'b0, 2'b10, 1'b0, 9'h040, 32'h0, 0);

    // Randomized traffic in a small window so stores and loads overlap.
    for (int k = 0; k < 150; k++) begin
      we   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      size = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      addr = 9'($urandom_range(0, 63));
      if ($urandom_range(0, 9) < 7 && size != 2'b11)
        addr = addr & ~9'(size_bytes(size) - 1);
      do_req(we, size, uns, addr, $urandom, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
